// File: rtl/poly_pkg.sv
`default_nettype none
// ============================================================================
// Package     : poly_pkg
// Description : Shared FSM state type and carry width for the chunked
//               GF(2)[x] multiply-by-(x^4 + x^2) datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package poly_pkg;

  // One chunk of carry covers the largest shift (x^4) of the multiplier
  localparam int CARRY_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : poly_pkg
`default_nettype wire

// File: rtl/mul_chunk_x4_plus_x2.sv
`default_nettype none
// ============================================================================
// Module      : mul_chunk_x4_plus_x2
// Description : Combinational slice of r = (p<<4) ^ (p<<2) over one W-bit
//               chunk. The carry holds the previous chunk's top 4 bits, so
//               ext = {chunk, carry} is the operand window aligned to x^-4.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_chunk_x4_plus_x2
  import poly_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0]       chunk,
  input  logic [CARRY_W-1:0] carry,
  output logic [W-1:0]       out,
  output logic [CARRY_W-1:0] carry_next
);

  logic [W+CARRY_W-1:0] w_ext;

  assign w_ext      = {chunk, carry};
  // out[j] = ext[j+2] ^ ext[j]: x^2 term from ext[j+2], x^4 term from ext[j]
  assign out        = W'((w_ext >> 2) ^ w_ext);
  assign carry_next = chunk[W-1:W-CARRY_W];

endmodule : mul_chunk_x4_plus_x2
`default_nettype wire

// File: rtl/mul_by_x4_plus_x2_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_by_x4_plus_x2_seq
// Description : Multi-cycle GF(2)[x] multiplier r = p * (x^4 + x^2) mod x^N,
//               one W-bit chunk per cycle, LSB chunk first, 4-bit carry
//               between chunks. done pulses one cycle with r valid.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_by_x4_plus_x2_seq
  import poly_pkg::*;
#(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] p,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] r
);

  localparam int          NCHUNK = N / W;
  localparam int          CNT_W  = $clog2(NCHUNK) + 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NCHUNK - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N-1:0]         op_q, op_d;
  logic [CARRY_W-1:0]   carry_q, carry_d;
  logic [N-1:0]         r_q, r_d;

  logic [W-1:0]         w_chunk_out;
  logic [CARRY_W-1:0]   w_carry_next;

  // Operand register shifts right each RUN cycle, so chunk k is always at the bottom
  mul_chunk_x4_plus_x2 #(
    .W (W)
  ) u_chunk (
    .chunk      (op_q[W-1:0]),
    .carry      (carry_q),
    .out        (w_chunk_out),
    .carry_next (w_carry_next)
  );

  // State and datapath registers; async reset returns everything to idle/zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      carry_q <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      r_q     <= r_d;
    end
  end

  // Next-state, datapath update and status outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    carry_d = carry_q;
    r_d     = r_q;
    busy    = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = p;
          carry_d = '0;
          cnt_d   = '0;
          r_d     = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        busy                 = 1'b1;
        r_d[cnt_q*W +: W]    = w_chunk_out;
        carry_d              = w_carry_next;
        op_d                 = op_q >> W;
        cnt_d                = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_K) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done = 1'b1;
        // A start here chains straight into the next operation
        if (start) begin
          op_d    = p;
          carry_d = '0;
          cnt_d   = '0;
          r_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign r = r_q;

endmodule : mul_by_x4_plus_x2_seq
`default_nettype wire

// File: tb/tb_mul_by_x4_plus_x2_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_by_x4_plus_x2_seq
// Description : Self-checking bench for mul_by_x4_plus_x2_seq (N=64, W=16)
//               against a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_by_x4_plus_x2_seq;

  localparam int N = 64;
  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] p;
  logic         busy;
  logic         done;
  logic [N-1:0] r;

  int n_checks = 0;
  int n_fail   = 0;

  mul_by_x4_plus_x2_seq #(
    .N (N),
    .W (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: full-width carry-less product truncated to 64 bits
  function automatic logic [63:0] mul_model(input logic [63:0] a);
    return (a << 4) ^ (a << 2);
  endfunction

  // Exact division by x^2*(x^2+1): drop x^2, then solve s = q*(1+x^2) LSB first
  function automatic logic [63:0] div_model(input logic [63:0] v);
    logic [63:0] s;
    logic [63:0] q;
    s = v >> 2;
    q = '0;
    for (int i = 0; i < 64; i++) begin
      q[i] = s[i] ^ ((i >= 2) ? q[i-2] : 1'b0);
    end
    return q;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // One operation: start accepted at E0, expect done 5 edges later (counting E0)
  task automatic run_op(input logic [63:0] pv, input string tag, output logic [63:0] res);
    int lat;
    @(negedge clk);
    p     = pv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    p     = rand64();
    check_eq({tag, " busy"}, 64'(busy), 64'd1);
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'd5);
    check_eq({tag, " r"}, r, mul_model(pv));
    res = r;
    @(posedge clk);
    #1;
    check_eq({tag, " done pulse"}, 64'(done), 64'd0);
  endtask

  initial begin : main
    logic [63:0] res;
    logic [63:0] pat [0:9];
    logic        exp_done;

    rst   = 1'b1;
    start = 1'b0;
    p     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset r",    r,         64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases with hand-derived products
    run_op(64'h1, "p=1", res);
    check_eq("p=1 const", res, 64'h14);
    run_op(64'h8000, "p=8000", res);
    check_eq("p=8000 const", res, 64'h000A_0000);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, "p=ones", res);
    check_eq("p=ones const", res, 64'hC);
    run_op(64'h8000_0000_0000_0000, "p=msb", res);
    check_eq("p=msb const", res, 64'h0);

    // Divide/multiply round trip
    run_op(64'h0000_0000_0000_ABCC, "roundtrip", res);
    check_eq("roundtrip div", div_model(res), 64'h0000_0000_0000_ABCC);

    // Random operands
    for (int i = 0; i < 20; i++) begin
      run_op(rand64(), $sformatf("rand%0d", i), res);
    end

    // start held high with p changing every cycle; re-accept in DONE
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      pat[e] = rand64();
      p      = pat[e];
      start  = 1'b1;
      @(posedge clk);
      #1;
      exp_done = (e == 4) || (e == 9);
      check_eq($sformatf("held e%0d done", e), 64'(done), 64'(exp_done));
      check_eq($sformatf("held e%0d busy", e), 64'(busy), 64'(!exp_done));
      if (e == 4) check_eq("held first r",  r, mul_model(pat[0]));
      if (e == 9) check_eq("held second r", r, mul_model(pat[5]));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("held idle busy", 64'(busy), 64'd0);
    check_eq("held idle done", 64'(done), 64'd0);

    // Asynchronous reset in the middle of an operation (k=2)
    @(negedge clk);
    p     = 64'hFFFF_FFFF_FFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst busy", 64'(busy), 64'd0);
    check_eq("midrst done", 64'(done), 64'd0);
    check_eq("midrst r",    r,         64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(64'h0123_4567_89AB_CDEF, "after rst", res);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_mul_by_x4_plus_x2_seq
`default_nettype wire
